// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg_scan_ctrl : multiplexed seven-segment scan controller with a
//                 double-buffered valid/ready load. Optional feature macro:
//                 SEG_LZB_EN (leading-zero blanking).
// Revision: 1.0
// ============================================================================
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic [3:0]          ones,
  output logic [DIGITS-1:0]   anode_n,
  output logic                frame_tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] C_GUARD    = CNT_W'(GUARD);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  logic [CNT_W-1:0]    r_slot_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_active_val;
  logic [DIGITS-1:0]   r_active_mask;
  logic [4*DIGITS-1:0] r_shadow_val;
  logic [DIGITS-1:0]   r_shadow_mask;
  logic                r_pending;
  logic [3:0]          r_ones;
  logic [DIGITS-1:0]   r_anode_n;

  logic                w_slot_wrap;
  logic                w_boundary;
  logic                w_accept;
  logic [DIGITS-1:0]   w_lz;
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_anode_d;

  assign w_slot_wrap = (r_slot_cnt == C_CNT_LAST);
  assign w_boundary  = w_slot_wrap && (r_idx == C_IDX_LAST);
  assign w_accept    = load_valid && !r_pending;

  assign load_ready = !r_pending;
  assign frame_tick = w_boundary;
  assign ones       = r_ones;
  assign anode_n    = r_anode_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else begin
      if (w_slot_wrap) begin
        r_slot_cnt <= '0;
        if (r_idx == C_IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + C_IDX_ONE;
        end
      end else begin
        r_slot_cnt <= r_slot_cnt + C_CNT_ONE;
      end
    end
  end

  // Shadow only reaches active at a frame boundary, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active_val  <= '0;
      r_active_mask <= '0;
      r_shadow_val  <= '0;
      r_shadow_mask <= '0;
      r_pending     <= 1'b0;
    end else begin
      if (w_boundary && r_pending) begin
        r_active_val  <= r_shadow_val;
        r_active_mask <= r_shadow_mask;
        r_pending     <= 1'b0;
      end else if (w_accept) begin
        r_shadow_val  <= value;
        r_shadow_mask <= blank_mask;
        r_pending     <= 1'b1;
      end
    end
  end

  always_comb begin
    w_lz = '0;
`ifdef SEG_LZB_EN
    begin : g_lzb
      logic w_zero_run;
      w_zero_run = 1'b1;
      // Walk down from the most significant digit; digit 0 is never suppressed.
      for (int i = DIGITS - 1; i > 0; i--) begin
        w_zero_run = w_zero_run && (r_active_val[4*i +: 4] == 4'h0);
        w_lz[i]    = w_zero_run;
      end
    end
`endif
  end

  assign w_blank = r_active_mask | w_lz;

  always_comb begin
    w_nib     = 4'h0;
    w_anode_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib        = r_active_val[4*i +: 4];
        w_anode_d[i] = !((r_slot_cnt >= C_GUARD) && !w_blank[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones    <= 4'h0;
      r_anode_n <= '1;
    end else begin
      r_ones    <= w_nib;
      r_anode_n <= w_anode_d;
    end
  end

endmodule
`default_nettype wire
